// File: rtl/pl_rv32_fetch.sv
// ============================================================================
// Module   : pl_rv32_fetch
// Purpose  : RV32I fetch stage: PC, one-outstanding imem requests, IF/ID buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pl_rv32_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_fault
);

    localparam logic [1:0]  ST_REQ   = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_DROP  = 2'd2;
    localparam logic [1:0]  ST_HALT  = 2'd3;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_fault_q, id_fault_d;

    logic        buf_free;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_load;
    logic [31:0] pc_plus4;

    always_comb begin
        buf_free  = !id_valid_q || id_ready;
        // Gated by rst so nothing is requested while the memory is held in reset.
        req_valid = !rst && (state_q == ST_REQ) && buf_free;
        req_fire  = req_valid && imem_req_ready;
        rsp_load  = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid;
        pc_plus4  = pc_q + 32'd4;
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            case (state_q)
                ST_REQ:  state_d = req_fire ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ:  if (req_fire) state_d = ST_WAIT;
                ST_WAIT: if (imem_rsp_valid) state_d = imem_rsp_err ? ST_HALT : ST_REQ;
                ST_DROP: if (imem_rsp_valid) state_d = ST_REQ;
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_comb begin
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_fault_d    = id_fault_q;

        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end
        if (rsp_load) begin
            id_valid_d    = 1'b1;
            id_instr_d    = imem_rsp_err ? NOP_INSN : imem_rsp_data;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_fault_d    = imem_rsp_err;
            pc_d          = pc_plus4;
        end
        // A redirect flushes the buffer and wins over any same-cycle load.
        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSN;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            id_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_fault_q    <= id_fault_d;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign id_valid       = id_valid_q;
    assign id_instr       = id_instr_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_plus4_q;
    assign id_fault       = id_fault_q;

endmodule

`default_nettype wire
